// File: rtl/branch_fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-side next-PC controller.
// Imported by branch_fetch_ctrl and its sub-modules.
package branch_fetch_ctrl_pkg;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_slot_t;

  localparam pred_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for branch statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up on inc until all-ones, then hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/branch_fetch_ctrl.sv
// Next-PC controller: follows BHT predictions, checks them in EX,
// redirects and flushes on a wrong next PC, and strobes BHT updates.
module branch_fetch_ctrl
  import branch_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [31:0]      if_pc,
  input  logic             bht_pre_result,
  input  logic [31:0]      bht_if_pre_dest,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             bht_op,
  output logic [31:0]      bht_pc,
  output logic [31:0]      bht_dest,
  output logic             bht_success,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  pred_slot_t  id_slot;
  pred_slot_t  ex_slot;
  logic        res;
  logic        mispredict;
  logic [31:0] seq_pc;
  logic [31:0] actual_next;
  logic [31:0] pred_next;
  logic [31:0] pc_next;

  // EX resolution: compare the carried prediction with the real next PC
  always_comb begin
    res         = ex_slot.valid & ex_valid;
    seq_pc      = ex_slot.pc + PC_STEP;
    actual_next = (ex_is_branch & ex_taken) ? ex_target : seq_pc;
    pred_next   = ex_slot.pred_taken ? ex_slot.pred_target : seq_pc;
    mispredict  = res & (actual_next != pred_next);
  end

  assign flush       = mispredict;
  assign bht_op      = res & ex_is_branch;
  assign bht_pc      = ex_slot.pc;
  assign bht_dest    = ex_target;
  assign bht_success = ex_taken;

  // next fetch address; a redirect beats a stall
  always_comb begin
    pc_next = if_pc + PC_STEP;
    if (mispredict) begin
      pc_next = actual_next;
    end else if (stall) begin
      pc_next = if_pc;
    end else if (bht_pre_result) begin
      pc_next = bht_if_pre_dest;
    end
  end

  // PC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_pc <= RESET_PC;
    end else begin
      if_pc <= pc_next;
    end
  end

  // prediction tracking through ID and EX; stall leaves a bubble in EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_slot <= SLOT_EMPTY;
      ex_slot <= SLOT_EMPTY;
    end else if (mispredict) begin
      id_slot.valid <= 1'b0;
      ex_slot.valid <= 1'b0;
    end else if (stall) begin
      ex_slot.valid <= 1'b0;
    end else begin
      id_slot <= '{
        valid:       1'b1,
        pc:          if_pc,
        pred_taken:  bht_pre_result,
        pred_target: bht_if_pre_dest
      };
      ex_slot <= id_slot;
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bht_op),
    .cnt (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mispredict),
    .cnt (mispredict_cnt)
  );

endmodule

// File: doc/branch_fetch_ctrl.md
Name:
branch_fetch_ctrl

Overview:
- Fetch-side next-PC controller for the pipelined MIPS core. Sits directly upstream of the branch history table: drives the IF lookup address and consumes its IF prediction.
- Carries each fetched instruction's prediction through ID to EX and compares it with the EX-stage resolution.
- On a wrong next PC it generates a flush and a redirect.
- Produces the one-cycle BHT update strobe with PC, target and outcome.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock
rst  in  1  reset
stall  in  1  load-use hazard: hold IF and ID, insert a bubble into EX
if_pc  out  32  current fetch PC; feeds IMEM and the BHT IF lookup address
bht_pre_result  in  1  BHT predicts taken for if_pc
bht_if_pre_dest  in  32  BHT predicted target for if_pc
ex_valid  in  1  EX holds a real instruction
ex_is_branch  in  1  EX instruction is a BHT-tracked branch/jump
ex_taken  in  1  actual branch outcome in EX
ex_target  in  32  actual branch target in EX
bht_op  out  1  BHT update strobe
bht_pc  out  32  PC of the resolved branch
bht_dest  out  32  actual target of the resolved branch
bht_success  out  1  actual outcome of the resolved branch
flush  out  1  kill the IF/ID and ID/EX pipeline registers
branch_cnt  out  CNT_W  resolved-branch count, saturating
mispredict_cnt  out  CNT_W  redirect count, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named rst.
- Reset values: if_pc = RESET_PC; both tracking slots invalid; counters 0. flush and bht_op are therefore 0.
- State:
  - PC register.
  - Two tracking slots, id_slot and ex_slot, each holding {valid, pc[31:0], pred_taken, pred_target[31:0]}.
- EX resolution is combinational from ex_slot and the ex_* inputs. Let res = ex_slot.valid & ex_valid.
  - seq = ex_slot.pc + 4, modulo 2^32.
  - actual_next = (ex_is_branch & ex_taken) ? ex_target : seq.
  - pred_next = ex_slot.pred_taken ? ex_slot.pred_target : seq.
  - mispredict = res & (actual_next != pred_next). This also covers a false BHT hit on a non-branch, which is redirected to seq.
- Outputs, all combinational:
  - flush = mispredict.
  - bht_op = res & ex_is_branch.
  - bht_pc = ex_slot.pc; bht_dest = ex_target; bht_success = ex_taken.
- Next PC, in priority order:
  1. mispredict -> actual_next.
  2. stall -> hold.
  3. bht_pre_result -> bht_if_pre_dest.
  4. Otherwise if_pc + 4, wrapping 0xFFFF_FFFC -> 0.
- Slot update at each posedge:
  - mispredict: id_slot.valid = 0 and ex_slot.valid = 0. Flush overrides stall.
  - stall: id_slot holds; ex_slot.valid = 0 (bubble).
  - otherwise: id_slot <= {1, if_pc, bht_pre_result, bht_if_pre_dest}; ex_slot <= id_slot.
- Each instruction is in ex_slot for exactly one cycle, so bht_op pulses once per branch. A stall bubble never strobes.
- Latency: prediction redirect takes 0 extra cycles (next posedge). Mispredict penalty is 2 cycles (IF and ID killed).
- Counters:
  - branch_cnt +1 on bht_op; mispredict_cnt +1 on mispredict.
  - Both increment in the same cycle if both fire.
  - Both saturate at all-ones.
- rst mid-operation: immediate return to the reset values; any in-flight bht_op is dropped.

Decomposition:
- Shared package:
  - PC_STEP = 4.
  - RESET_PC default.
  - pred_slot_t typedef {valid, pc, pred_taken, pred_target}.
- One sub-module: sat_counter (parameter W; inc input; clk/rst; saturating). Instantiated twice.

Test Plan:
- Reset: run to if_pc=0x18, pulse rst asynchronously -> if_pc=0x0 before the next edge; counters=0; flush=0; bht_op=0.
- Sequential fetch: no BHT hits, no branches -> if_pc 0x0,0x4,0x8,0xC on successive cycles; flush never 1.
- Correct taken prediction: at if_pc=0x10, bht_pre_result=1 with dest 0x40 -> next if_pc=0x40. Two cycles later, EX taken to 0x40 -> flush=0, bht_op=1, bht_pc=0x10, bht_success=1, branch_cnt=1.
- Mispredict: 0x20 fetched unpredicted; EX reports taken to 0x80 -> flush=1 that cycle; next if_pc=0x80; both slots invalid; branch_cnt=1, mispredict_cnt=1. False hit on a non-branch at 0x30 predicted 0x50 -> redirect to 0x34.
- Stall: stall=1 for 2 cycles at if_pc=0x8 -> if_pc holds 0x8, bht_op=0 in the bubble cycles. Mispredict arriving while stall=1 -> redirect still taken.
- Boundaries: CNT_W=2 with 5 mispredicts -> mispredict_cnt stays 3. if_pc=0xFFFF_FFFC with no hit -> next if_pc=0x0.
